// File: rtl/eg_syntax_arbiter.sv
// eg_syntax_arbiter
// Lets several CAVLC syntax-element sources share one Exp-Golomb ue(v)/se(v) encoder.
// Requesters are served round-robin. The pipeline has two stages:
//   S1 holds the granted requester id and its code number.
//   S2 holds the finished codeword, its length and the requester id, and drives the outputs.
// Both stages use valid/ready handshakes, so one element can complete every cycle.
module eg_syntax_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int VAL_W   = 8,
    localparam int CW      = 2*VAL_W+1,
    localparam int LW      = $clog2(CW+1),
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_signed,
    input  logic [NUM_REQ*VAL_W-1:0] req_value,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_codebit,
    output logic [LW-1:0]            out_len,
    output logic [IW-1:0]            out_id
);

    // pipeline and arbitration state
    logic               s1_valid_q,    s1_valid_d;
    logic [VAL_W:0]     s1_codenum_q,  s1_codenum_d;
    logic [IW-1:0]      s1_id_q,       s1_id_d;
    logic               out_valid_q,   out_valid_d;
    logic [CW-1:0]      out_codebit_q, out_codebit_d;
    logic [LW-1:0]      out_len_q,     out_len_d;
    logic [IW-1:0]      out_id_q,      out_id_d;
    logic [IW-1:0]      rr_ptr_q,      rr_ptr_d;

    // combinational helpers
    logic               adv1;
    logic               adv2;
    logic               any_req;
    logic               accept;
    logic [IW-1:0]      grant;
    logic [VAL_W-1:0]   grant_value;
    logic               grant_signed;
    logic [VAL_W-1:0]   grant_neg;
    logic [VAL_W:0]     grant_codenum;
    logic [VAL_W:0]     cn_plus1;
    logic [LW-2:0]      msb_pos;

    // Returns (base + k) mod NUM_REQ, for 0 <= k < NUM_REQ.
    // This works for any NUM_REQ, not only powers of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IW'(sum);
    endfunction

    // Stage-advance conditions.
    // S2 can take a new element when it is empty or the packer is draining it.
    // S1 can take a new element when it is empty or S2 can take S1's element.
    always_comb begin
        adv2 = !out_valid_q || out_ready;
        adv1 = !s1_valid_q || adv2;
    end

    // Round-robin search.
    // Scan from rr_ptr upward; the first valid requester wins.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_req && req_valid[wrap_add(rr_ptr_q, k)]) begin
                any_req = 1'b1;
                grant   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // Accept gating: clr blocks any accept, and a full, stalled S1 blocks accepts too.
    // The ready vector is at most one-hot.
    always_comb begin
        accept    = adv1 && !clr && any_req;
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Map the granted value to its code number.
    // ue: the value is used as-is.
    // se: a positive v maps to 2v-1; a zero or negative v maps to -2v.
    // The most negative value maps to 2^VAL_W. That is why the code number is VAL_W+1 bits wide.
    always_comb begin
        grant_value   = req_value[int'(grant)*VAL_W +: VAL_W];
        grant_signed  = req_signed[grant];
        grant_neg     = '0 - grant_value;
        grant_codenum = '0;
        if (!grant_signed) begin
            grant_codenum = {1'b0, grant_value};
        end else if (!grant_value[VAL_W-1] && (grant_value != '0)) begin
            grant_codenum = {grant_value, 1'b0} - {{VAL_W{1'b0}}, 1'b1};
        end else begin
            grant_codenum = {grant_neg, 1'b0};
        end
    end

    // Build the codeword.
    // The codeword is codenum+1, right-aligned.
    // Its length is 2*M+1, where M is the index of the top set bit of codenum+1.
    // M comes from a priority encoder. The length is formed by appending a 1 to M, so no adder is needed.
    always_comb begin
        cn_plus1 = s1_codenum_q + {{VAL_W{1'b0}}, 1'b1};
        msb_pos  = '0;
        for (int b = 0; b <= VAL_W; b++) begin
            if (cn_plus1[b]) begin
                msb_pos = (LW-1)'(b);
            end
        end
    end

    // Next-state logic.
    // clr wins: it empties both stages and rewinds the pointer, and leaves the output data as it is.
    // Otherwise each stage moves when it is allowed to advance.
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_codenum_d  = s1_codenum_q;
        s1_id_d       = s1_id_q;
        out_valid_d   = out_valid_q;
        out_codebit_d = out_codebit_q;
        out_len_d     = out_len_q;
        out_id_d      = out_id_q;
        rr_ptr_d      = rr_ptr_q;
        if (clr) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
            rr_ptr_d    = '0;
        end else begin
            if (adv2) begin
                out_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    out_codebit_d = {{(CW-VAL_W-1){1'b0}}, cn_plus1};
                    out_len_d     = {msb_pos, 1'b1};
                    out_id_d      = s1_id_q;
                end
            end
            if (adv1) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_codenum_d = grant_codenum;
                    s1_id_d      = grant;
                end
            end
            if (accept) begin
                rr_ptr_d = wrap_add(grant, 1);
            end
        end
    end

    // State registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_codenum_q  <= '0;
            s1_id_q       <= '0;
            out_valid_q   <= 1'b0;
            out_codebit_q <= '0;
            out_len_q     <= '0;
            out_id_q      <= '0;
            rr_ptr_q      <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_codenum_q  <= s1_codenum_d;
            s1_id_q       <= s1_id_d;
            out_valid_q   <= out_valid_d;
            out_codebit_q <= out_codebit_d;
            out_len_q     <= out_len_d;
            out_id_q      <= out_id_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    // The outputs come directly from the S2 registers.
    always_comb begin
        out_valid   = out_valid_q;
        out_codebit = out_codebit_q;
        out_len     = out_len_q;
        out_id      = out_id_q;
    end

endmodule

// File: tb/tb_eg_syntax_arbiter.sv
// tb_eg_syntax_arbiter
// Self-checking bench for eg_syntax_arbiter.
// Each requester has its own queue of elements. An element carries its expected codeword.
// A reference model predicts the grant and the pipeline occupancy every cycle.
// On each accept the model pushes the expected response into a scoreboard.
// A separate monitor compares whatever the DUT presents against the front of the scoreboard.
module tb_eg_syntax_arbiter;

    localparam int NUM_REQ = 4;
    localparam int VAL_W   = 8;
    localparam int CW      = 2*VAL_W+1;
    localparam int LW      = $clog2(CW+1);
    localparam int IW      = $clog2(NUM_REQ);

    logic                     clk;
    logic                     rst_n;
    logic                     clr;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_signed;
    logic [NUM_REQ*VAL_W-1:0] req_value;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic [CW-1:0]            out_codebit;
    logic [LW-1:0]            out_len;
    logic [IW-1:0]            out_id;

    typedef struct {
        logic             sgn;
        logic [VAL_W-1:0] val;
        logic [CW-1:0]    cw;
        logic [LW-1:0]    len;
    } item_t;

    typedef struct {
        logic [CW-1:0] cw;
        logic [LW-1:0] len;
        logic [IW-1:0] id;
    } exp_t;

    item_t pend [NUM_REQ][$];
    exp_t  sb [$];
    int    id_log [$];
    int    t_log [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    bit drv_en     = 0;
    bit ready_rand = 0;
    int hold_pct   = 0;
    int ready_pct  = 100;

    bit m_s1v = 0;
    bit m_s2v = 0;
    int rr    = 0;

    logic [NUM_REQ-1:0]       prev_wait = '0;
    logic [NUM_REQ*VAL_W-1:0] prev_val  = '0;

    eg_syntax_arbiter #(.NUM_REQ(NUM_REQ), .VAL_W(VAL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_signed (req_signed),
        .req_value  (req_value),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_codebit(out_codebit),
        .out_len    (out_len),
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle stamp. It is used to check back-to-back output timing.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic item_t hand_item(input logic sgn, input logic [VAL_W-1:0] v,
                                        input logic [CW-1:0] cw, input logic [LW-1:0] len);
        item_t it;
        it.sgn = sgn;
        it.val = v;
        it.cw  = cw;
        it.len = len;
        return it;
    endfunction

    // Reference encoder, written with plain integer arithmetic.
    function automatic item_t mk_item(input logic sgn, input logic [VAL_W-1:0] v);
        item_t it;
        int    s;
        int    cn;
        int    m;
        s = sgn ? int'($signed(v)) : int'(v);
        if (!sgn)       cn = s;
        else if (s > 0) cn = 2*s - 1;
        else            cn = -2*s;
        m = 0;
        while ((1 << (m+1)) <= cn + 1) m++;
        it.sgn = sgn;
        it.val = v;
        it.cw  = CW'(cn + 1);
        it.len = LW'(2*m + 1);
        return it;
    endfunction

    task automatic applyStimulus(input int r, input item_t it);
        pend[r].push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (sb.size() == 0) && (req_valid == '0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() != 0) idle = 0;
        end
        return idle;
    endfunction

    task automatic wait_idle(input string tag, input int max_cyc);
        bit done;
        done = 0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            tick(1);
            done = all_idle();
        end
        checkOutput({"drain_", tag}, 32'(done), 32'd1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    // Requester driver.
    // It presents the head of each queue and holds it until accepted.
    // It pops the head once a transfer has been seen.
    // Idle requesters get random values, so their inputs should never leak into the outputs.
    initial begin : driver
        logic [NUM_REQ-1:0] acc;
        forever begin
            @(negedge clk);
            acc = rst_n ? (req_valid & req_ready) : '0;
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
                if (req_valid[i] && !acc[i]) begin
                    req_valid[i] = 1'b1;
                end else if (drv_en && pend[i].size() > 0 && int'($urandom_range(99)) >= hold_pct) begin
                    req_valid[i]                 = 1'b1;
                    req_signed[i]                = pend[i][0].sgn;
                    req_value[i*VAL_W +: VAL_W]  = pend[i][0].val;
                end else begin
                    req_valid[i]                 = 1'b0;
                    req_signed[i]                = 1'($urandom);
                    req_value[i*VAL_W +: VAL_W]  = VAL_W'($urandom);
                end
            end
            if (ready_rand) out_ready = (int'($urandom_range(99)) < ready_pct);
        end
    end

    // Requester obligation: a valid element stays unchanged until it is accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (prev_wait[i]) begin
                    assert (req_valid[i] && req_value[i*VAL_W +: VAL_W] == prev_val[i*VAL_W +: VAL_W])
                        else $error("[TB] requester %0d changed before accept", i);
                end
            end
        end
        prev_wait <= rst_n ? (req_valid & ~req_ready) : '0;
        prev_val  <= req_value;
    end

    // Reference model.
    // It predicts the round-robin grant and the occupancy of both stages.
    // On each accept it pushes the expected response into the scoreboard.
    always @(negedge clk) begin : model
        logic [NUM_REQ-1:0] exp_rdy;
        int    g;
        int    idx;
        bit    a1;
        bit    a2;
        exp_t  e;
        #1;
        if (!rst_n) begin
            m_s1v = 0;
            m_s2v = 0;
            rr    = 0;
            sb.delete();
        end else begin
            checkOutput("out_valid", 32'(out_valid), 32'(m_s2v));
            a2      = !m_s2v || out_ready;
            a1      = !m_s1v || a2;
            exp_rdy = '0;
            g       = -1;
            if (a1 && !clr) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (rr + k) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            checkOutput("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (clr) begin
                m_s1v = 0;
                m_s2v = 0;
                rr    = 0;
                sb.delete();
            end else begin
                if (a2) m_s2v = m_s1v;
                if (a1) m_s1v = (g >= 0);
                if (g >= 0 && pend[g].size() > 0) begin
                    e.cw  = pend[g][0].cw;
                    e.len = pend[g][0].len;
                    e.id  = IW'(g);
                    sb.push_back(e);
                    rr = (g + 1) % NUM_REQ;
                end
            end
        end
    end

    // Output monitor.
    // While out_valid is high it compares the outputs with the oldest expected element.
    // It pops that element on a real transfer.
    always @(negedge clk) begin : monitor
        if (rst_n && out_valid) begin
            checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                checkOutput("out_codebit", 32'(out_codebit), 32'(sb[0].cw));
                checkOutput("out_len",     32'(out_len),     32'(sb[0].len));
                checkOutput("out_id",      32'(out_id),      32'(sb[0].id));
                if (out_ready && !clr) begin
                    void'(sb.pop_front());
                    id_log.push_back(int'(out_id));
                    t_log.push_back(cyc);
                end
            end
        end
    end

    initial begin : main
        req_valid  = '0;
        req_signed = '0;
        req_value  = '0;
        out_ready  = 1'b1;
        clr        = 1'b0;
        rst_n      = 1'b1;
        #3 rst_n   = 1'b0;
        tick(2);
        checkOutput("rst_out_valid",   32'(out_valid),   32'd0);
        checkOutput("rst_out_codebit", 32'(out_codebit), 32'd0);
        checkOutput("rst_out_len",     32'(out_len),     32'd0);
        checkOutput("rst_out_id",      32'(out_id),      32'd0);
        rst_n = 1'b1;
        tick(1);

        // T1: a single se(-3) from requester 0 gives codeword 00111 with length 5
        drv_en = 1;
        applyStimulus(0, hand_item(1'b1, 8'hFD, 17'h00007, 5'd5));
        wait_idle("t1", 20);

        // T2: the mapping corner cases
        applyStimulus(0, hand_item(1'b0, 8'h00, 17'h00001, 5'd1));
        applyStimulus(1, hand_item(1'b1, 8'h01, 17'h00002, 5'd3));
        applyStimulus(2, hand_item(1'b0, 8'hFF, 17'h00100, 5'd17));
        applyStimulus(3, hand_item(1'b1, 8'h80, 17'h00101, 5'd17));
        applyStimulus(0, hand_item(1'b1, 8'h7F, 17'h000FE, 5'd15));
        wait_idle("t2", 40);

        // T3: all four requesters valid continuously, so ids rotate 0..3 once per cycle
        drv_en = 0;
        do_clr();
        id_log.delete();
        t_log.delete();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                applyStimulus(i, mk_item(1'(k), VAL_W'(i*16 + k*5 + 1)));
            end
        end
        drv_en = 1;
        wait_idle("t3", 60);
        checkOutput("t3_count", 32'(id_log.size()), 32'd12);
        for (int j = 0; j < id_log.size() && j < 12; j++) begin
            checkOutput($sformatf("t3_id%0d", j), 32'(id_log[j]), 32'(j % 4));
        end
        if (t_log.size() == 12) checkOutput("t3_back_to_back", 32'(t_log[11] - t_log[0]), 32'd11);

        // T4: backpressure with three elements pending
        out_ready = 1'b0;
        drv_en    = 0;
        do_clr();
        id_log.delete();
        applyStimulus(1, hand_item(1'b0, 8'h04, 17'h00005, 5'd5));
        applyStimulus(2, hand_item(1'b1, 8'hFF, 17'h00003, 5'd3));
        applyStimulus(3, hand_item(1'b0, 8'h07, 17'h00008, 5'd7));
        drv_en = 1;
        tick(5);
        checkOutput("t4_ready_stalled", 32'(req_ready),   32'd0);
        checkOutput("t4_valid_held",    32'(out_valid),   32'd1);
        checkOutput("t4_id_held",       32'(out_id),      32'd1);
        checkOutput("t4_cw_held",       32'(out_codebit), 32'h5);
        out_ready = 1'b1;
        wait_idle("t4", 40);
        checkOutput("t4_count", 32'(id_log.size()), 32'd3);
        for (int j = 0; j < id_log.size() && j < 3; j++) begin
            checkOutput($sformatf("t4_id%0d", j), 32'(id_log[j]), 32'(j + 1));
        end

        // T5: clr while both stages are full. The next grant must restart from id 0
        out_ready = 1'b0;
        drv_en    = 0;
        do_clr();
        id_log.delete();
        applyStimulus(1, hand_item(1'b0, 8'h01, 17'h00002, 5'd3));
        applyStimulus(2, hand_item(1'b0, 8'h02, 17'h00003, 5'd3));
        drv_en = 1;
        tick(4);
        applyStimulus(3, hand_item(1'b0, 8'h03, 17'h00004, 5'd5));
        applyStimulus(0, hand_item(1'b1, 8'h02, 17'h00004, 5'd5));
        tick(2);
        checkOutput("t5_full_valid", 32'(out_valid), 32'd1);
        clr       = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("t5_ready_in_clr", 32'(req_ready), 32'd0);
        tick(1);
        clr = 1'b0;
        checkOutput("t5_valid_after_clr", 32'(out_valid), 32'd0);
        wait_idle("t5", 40);
        checkOutput("t5_count", 32'(id_log.size()), 32'd2);
        if (id_log.size() == 2) begin
            checkOutput("t5_first_id",  32'(id_log[0]), 32'd0);
            checkOutput("t5_second_id", 32'(id_log[1]), 32'd3);
        end

        // T6: random traffic against the reference model, with a reset pulse in the middle of the run
        hold_pct   = 30;
        ready_pct  = 70;
        ready_rand = 1;
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(int'($urandom_range(NUM_REQ-1)), mk_item(1'($urandom), VAL_W'($urandom)));
        end
        tick(3000);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        wait_idle("t6", 60000);
        ready_rand = 0;
        out_ready  = 1'b1;
        tick(3);
        checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
